// File: rtl/timing_pkg.sv
// Shared types and constants for the SLM timing controller.
package timing_pkg;

  typedef enum logic [2:0] {
    StPowerup,
    StFrameStart,
    StWaitLine,
    StLine,
    StUpdate,
    StSwitch,
    StDisplay
  } state_e;

  localparam int unsigned DefLinesPerFrame = 1280;
  localparam int unsigned DefLineCycles    = 40;
  localparam int unsigned DefUpdateCycles  = 4;
  localparam int unsigned DefDisplayCycles = 1000;
  localparam int unsigned DefPowerupCycles = 100;
  localparam int unsigned DefFrameCntW     = 16;

  // Ceiling log2; clog2(1) = 0, callers guard zero widths themselves.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/phase_counter.sv
// Loadable down-counter that flags when it has reached zero.
module phase_counter #(
  parameter int unsigned       Width    = 8,
  parameter logic [Width-1:0]  ResetVal = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  output logic             done_o
);

  logic [Width-1:0] cnt_q;

  // Load has priority; otherwise count down and stick at zero.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= ResetVal;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/timing_controller_mp.sv
// Frame sequencer for the SLM: power-up hold, per-frame reset, line loading,
// update/switch strobes, display hold, with optional DC-balance re-show.
module timing_controller_mp
  import timing_pkg::*;
#(
  parameter int unsigned LINES_PER_FRAME = DefLinesPerFrame,
  parameter int unsigned LINE_CYCLES     = DefLineCycles,
  parameter int unsigned UPDATE_CYCLES   = DefUpdateCycles,
  parameter int unsigned DISPLAY_CYCLES  = DefDisplayCycles,
  parameter int unsigned POWERUP_CYCLES  = DefPowerupCycles,
  parameter int unsigned FRAME_CNT_W     = DefFrameCntW,
  localparam int unsigned LineW = (clog2(LINES_PER_FRAME) > 0) ? clog2(LINES_PER_FRAME) : 1
) (
  input  logic                   fpga_clk,
  input  logic                   reset_all,
  input  logic                   dc32_fifo_almost_full,
  input  logic                   dc_balance_en,
  output logic                   reset_per_frame,
  output logic                   line_of_data_available,
  output logic                   update,
  output logic                   invert,
  output logic                   buffer_switch_done,
  output logic [LineW-1:0]       line_count,
  output logic [FRAME_CNT_W-1:0] frame_count,
  output logic                   busy
);

  localparam int unsigned Max1 = (LINE_CYCLES > UPDATE_CYCLES) ? LINE_CYCLES : UPDATE_CYCLES;
  localparam int unsigned Max2 = (DISPLAY_CYCLES > POWERUP_CYCLES) ? DISPLAY_CYCLES
                                                                   : POWERUP_CYCLES;
  localparam int unsigned MaxCycles = (Max1 > Max2) ? Max1 : Max2;
  localparam int unsigned PhaseW    = (clog2(MaxCycles) > 0) ? clog2(MaxCycles) : 1;
  // One extra code so the count can rest at LINES_PER_FRAME after the last line.
  localparam int unsigned LineIntW  = clog2(LINES_PER_FRAME + 1);

  if (LINES_PER_FRAME < 1 || LINE_CYCLES < 1 || UPDATE_CYCLES < 1 || DISPLAY_CYCLES < 1 ||
      POWERUP_CYCLES < 1 || FRAME_CNT_W < 1) begin : g_bad_params
    $error("timing_controller_mp: all parameters must be >= 1");
  end

  state_e                 state_q, state_d;
  logic [PhaseW-1:0]      load_val;
  logic                   load;
  logic                   phase_done;
  logic                   last_line;
  logic                   bal_q;
  logic [LineIntW-1:0]    line_q;
  logic [FRAME_CNT_W-1:0] frame_q;
  logic                   rpf_q, lda_q, upd_q, inv_q, bsd_q, busy_q;

  assign last_line = (line_q == LineIntW'(LINES_PER_FRAME - 1));

  // Next-state decode and the phase length to load on entering a state.
  always_comb begin
    state_d  = state_q;
    load_val = '0;
    unique case (state_q)
      StPowerup:    if (phase_done) state_d = StFrameStart;
      StFrameStart: state_d = StWaitLine;
      StWaitLine:   if (dc32_fifo_almost_full) state_d = StLine;
      StLine:       if (phase_done) state_d = last_line ? StUpdate : StWaitLine;
      StUpdate:     if (phase_done) state_d = StSwitch;
      StSwitch:     state_d = StDisplay;
      StDisplay:    if (phase_done) state_d = (bal_q && !inv_q) ? StUpdate : StFrameStart;
      default:      state_d = StPowerup;
    endcase
    unique case (state_d)
      StLine:    load_val = PhaseW'(LINE_CYCLES - 1);
      StUpdate:  load_val = PhaseW'(UPDATE_CYCLES - 1);
      StDisplay: load_val = PhaseW'(DISPLAY_CYCLES - 1);
      default:   load_val = '0;
    endcase
  end

  assign load = (state_d != state_q);

  phase_counter #(
    .Width    (PhaseW),
    .ResetVal (PhaseW'(POWERUP_CYCLES - 1))
  ) u_phase_counter (
    .clk_i      (fpga_clk),
    .rst_i      (reset_all),
    .load_i     (load),
    .load_val_i (load_val),
    .done_o     (phase_done)
  );

  // State register plus outputs registered from the state being entered.
  always_ff @(posedge fpga_clk or posedge reset_all) begin
    if (reset_all) begin
      state_q <= StPowerup;
      bal_q   <= 1'b0;
      line_q  <= '0;
      frame_q <= '0;
      rpf_q   <= 1'b0;
      lda_q   <= 1'b0;
      upd_q   <= 1'b0;
      inv_q   <= 1'b0;
      bsd_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rpf_q   <= (state_d == StFrameStart);
      lda_q   <= (state_d == StLine);
      upd_q   <= (state_d == StUpdate);
      bsd_q   <= (state_d == StSwitch);
      busy_q  <= (state_d != StPowerup);
      if (state_q == StFrameStart) begin
        bal_q <= dc_balance_en;
      end
      if (state_d == StFrameStart) begin
        line_q <= '0;
      end else if (state_q == StLine && phase_done) begin
        line_q <= line_q + 1'b1;
      end
      // Leaving display: either re-show inverted or close the frame.
      if (state_q == StDisplay && phase_done) begin
        if (bal_q && !inv_q) begin
          inv_q <= 1'b1;
        end else begin
          inv_q   <= 1'b0;
          frame_q <= frame_q + 1'b1;
        end
      end
    end
  end

  assign reset_per_frame        = rpf_q;
  assign line_of_data_available = lda_q;
  assign update                 = upd_q;
  assign invert                 = inv_q;
  assign buffer_switch_done     = bsd_q;
  assign line_count             = line_q[LineW-1:0];
  assign frame_count            = frame_q;
  assign busy                   = busy_q;

endmodule

// File: tb/tb_timing_controller_mp.sv
// Bench for timing_controller_mp: procedural frame model plus literal event checks.
module tb_timing_controller_mp;

  localparam int unsigned L  = 4;
  localparam int unsigned LC = 8;
  localparam int unsigned UC = 3;
  localparam int unsigned DC = 10;
  localparam int unsigned PC = 5;
  localparam int unsigned FW = 2;

  logic          fpga_clk  = 1'b0;
  logic          reset_all = 1'b0;
  logic          af        = 1'b0;
  logic          bal_en    = 1'b0;
  logic          rpf, lda, upd, inv, bsd, busy;
  logic [1:0]    line_count;
  logic [FW-1:0] frame_count;

  timing_controller_mp #(
    .LINES_PER_FRAME (L),
    .LINE_CYCLES     (LC),
    .UPDATE_CYCLES   (UC),
    .DISPLAY_CYCLES  (DC),
    .POWERUP_CYCLES  (PC),
    .FRAME_CNT_W     (FW)
  ) dut (
    .fpga_clk               (fpga_clk),
    .reset_all              (reset_all),
    .dc32_fifo_almost_full  (af),
    .dc_balance_en          (bal_en),
    .reset_per_frame        (rpf),
    .line_of_data_available (lda),
    .update                 (upd),
    .invert                 (inv),
    .buffer_switch_done     (bsd),
    .line_count             (line_count),
    .frame_count            (frame_count),
    .busy                   (busy)
  );

  always #5 fpga_clk = ~fpga_clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Cycles since reset release (edge k -> k).
  int cyc;
  always @(posedge fpga_clk or posedge reset_all) begin
    if (reset_all) cyc <= 0;
    else           cyc <= cyc + 1;
  end

  // ---------------- behavioural model ----------------
  logic       af_s, bal_s, ab, mvalid;
  logic [1:0] e_line, e_frame;
  logic [9:0] exp_v;
  logic [9:0] act_v;
  assign act_v = {rpf, lda, upd, inv, bsd, busy, line_count, frame_count};

  task automatic tick();
    @(posedge fpga_clk);
    af_s  = af;
    bal_s = bal_en;
    if (reset_all) ab = 1'b1;
  endtask

  task automatic set_exp(input logic r, input logic d, input logic u, input logic i,
                         input logic b);
    exp_v = {r, d, u, i, b, 1'b1, e_line, e_frame};
  endtask

  task automatic run_model();
    logic bal, iv;
    for (int i = 0; i < PC; i++) begin
      tick(); if (ab) return;
    end
    forever begin
      e_line = 2'd0;
      set_exp(1, 0, 0, 0, 0);
      tick(); if (ab) return;
      bal = bal_s;
      set_exp(0, 0, 0, 0, 0);
      for (int l = 0; l < L; l++) begin
        do begin
          tick(); if (ab) return;
          if (!af_s) set_exp(0, 0, 0, 0, 0);
        end while (!af_s);
        set_exp(0, 1, 0, 0, 0);
        for (int c = 1; c < LC; c++) begin
          tick(); if (ab) return;
          set_exp(0, 1, 0, 0, 0);
        end
        tick(); if (ab) return;
        e_line = e_line + 2'd1;  // reaches 4, shown as its low bits
        if (l < L - 1) set_exp(0, 0, 0, 0, 0);
      end
      iv = 1'b0;
      forever begin
        set_exp(0, 0, 1, iv, 0);
        for (int c = 1; c < UC; c++) begin
          tick(); if (ab) return;
          set_exp(0, 0, 1, iv, 0);
        end
        tick(); if (ab) return;
        set_exp(0, 0, 0, iv, 1);
        for (int c = 0; c < DC; c++) begin
          tick(); if (ab) return;
          set_exp(0, 0, 0, iv, 0);
        end
        tick(); if (ab) return;
        if (bal && !iv) iv = 1'b1;
        else break;
      end
      e_frame = e_frame + 2'd1;
    end
  endtask

  initial begin
    mvalid = 1'b0;
    forever begin
      wait (reset_all == 1'b1);
      mvalid = 1'b0;
      wait (reset_all == 1'b0);
      ab      = 1'b0;
      e_line  = 2'd0;
      e_frame = 2'd0;
      exp_v   = '0;
      mvalid  = 1'b1;
      run_model();
    end
  end

  // ---------------- compare and event logs ----------------
  logic run_chk = 1'b0;
  int   rpf_t[$];
  int   rpf_fc[$];
  int   upd_n = 0, upd_inv_n = 0, bsd_n = 0;

  always @(negedge fpga_clk) begin
    if (run_chk) begin
      if (reset_all) begin
        check("async_reset", 32'(act_v), 32'd0);
      end else if (mvalid) begin
        check("outputs{rpf,lda,upd,inv,bsd,busy,line,frame}", 32'(act_v), 32'(exp_v));
        if (rpf) begin
          rpf_t.push_back(cyc);
          rpf_fc.push_back(int'(frame_count));
        end
        if (upd) upd_n++;
        if (upd && inv) upd_inv_n++;
        if (bsd) bsd_n++;
      end
    end
  end

  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge fpga_clk);
      #1;
    end
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  int exp_t[8]  = '{5, 56, 121, 192, 243, 294, 5, 56};
  int exp_fc[8] = '{0, 1, 2, 3, 0, 1, 0, 1};

  initial begin
    #1 reset_all = 1'b1;
    run_chk = 1'b1;
    repeat (3) @(posedge fpga_clk);
    #2;
    reset_all = 1'b0;
    af        = 1'b1;
    wait_cyc(20);  bal_en = 1'b1;  // mid frame 1: frame 2 is balanced
    wait_cyc(80);  bal_en = 1'b0;  // mid frame 2: frame 3 is normal
    wait_cyc(135); af = 1'b0;      // starve the FIFO before line 2 of frame 3
    wait_cyc(150);
    @(negedge fpga_clk);
    check("stall_line_count", 32'(line_count), 32'd2);
    check("stall_lda", 32'(lda), 32'd0);
    wait_cyc(160); af = 1'b1;
    wait_cyc(318); reset_all = 1'b1;  // 5th cycle of line 2 (third line) in frame 6
    @(negedge fpga_clk);
    check("reset_outputs", 32'(act_v), 32'd0);
    repeat (3) @(posedge fpga_clk);
    #2;
    reset_all = 1'b0;
    wait_cyc(4);
    @(negedge fpga_clk);
    check("powerup_busy", 32'(busy), 32'd0);
    check("powerup_frame_count", 32'(frame_count), 32'd0);
    wait_cyc(62);
    @(negedge fpga_clk);
    check("rpf_pulse_count", 32'(rpf_t.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      if (i < rpf_t.size()) begin
        check($sformatf("rpf_cycle[%0d]", i), 32'(rpf_t[i]), 32'(exp_t[i]));
        check($sformatf("rpf_frame_count[%0d]", i), 32'(rpf_fc[i]), 32'(exp_fc[i]));
      end
    end
    check("update_cycles", 32'(upd_n), 32'd21);
    check("update_inverted_cycles", 32'(upd_inv_n), 32'd3);
    check("switch_pulses", 32'(bsd_n), 32'd7);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/timing_controller_mp.md
Name: timing_controller_mp

Overview:
- Parametrised successor to the single-mode SLM timing controller.
- Sequences each frame: power-up hold, per-frame reset pulse, line-by-line drain of the DC32 FIFO into the SLM, update strobe, buffer-switch pulse, display hold.
- Adds a run-time DC-balance mode: each frame is re-shown with invert=1 without reloading data.
- Adds generic frame geometry and timing, plus line and frame counters exported for debug and the host status path.

Parameters:
- LINES_PER_FRAME, 1280: lines loaded per frame.
- LINE_CYCLES, 40: cycles line_of_data_available stays high per line (one FIFO line burst).
- UPDATE_CYCLES, 4: width of the update strobe.
- DISPLAY_CYCLES, 1000: hold cycles after buffer switch before the next phase.
- POWERUP_CYCLES, 100: hold after reset release before the first frame.
- FRAME_CNT_W, 16: width of frame_count.

Ports:
- fpga_clk  in  1  system clock; all logic on the rising edge.
- reset_all  in  1  asynchronous, active-high reset.
- dc32_fifo_almost_full  in  1  FIFO holds at least one full line.
- dc_balance_en  in  1  DC-balance mode request; sampled once per frame.
- reset_per_frame  out  1  one-cycle pulse at the start of each frame.
- line_of_data_available  out  1  high while the downstream reads one line.
- update  out  1  SLM update strobe.
- invert  out  1  SLM polarity; stable throughout update and display.
- buffer_switch_done  out  1  one-cycle pulse after each update.
- line_count  out  clog2(LINES_PER_FRAME)  index of the current or next line.
- frame_count  out  FRAME_CNT_W  completed frames; wraps modulo 2^FRAME_CNT_W.
- busy  out  1  high in every state except POWERUP.

Behaviour:
- Reset: asynchronous, may assert at any cycle including mid-line. Forces state POWERUP and all outputs and counters to 0. The in-flight frame is abandoned and no partial pulses complete.
- All outputs are registered. Output values follow the state entered at each clock edge.
- POWERUP: counts POWERUP_CYCLES cycles from reset release, then goes to FRAME_START.
- FRAME_START (1 cycle):
  - reset_per_frame=1 and line_count cleared.
  - dc_balance_en is latched into bal_q; changes at any other time are ignored until the next frame.
  - Next state: WAIT_LINE.
- WAIT_LINE: waits for dc32_fifo_almost_full=1, then goes to LINE on the next edge. dc32_fifo_almost_full is ignored in every other state.
- LINE:
  - line_of_data_available=1 for exactly LINE_CYCLES consecutive cycles.
  - On the last cycle line_count increments.
  - If the completed line was LINES_PER_FRAME-1, go to UPDATE with invert=0; otherwise go to WAIT_LINE.
  - Back-to-back lines leave a minimum 1-cycle gap with line_of_data_available=0.
- UPDATE: update=1 for UPDATE_CYCLES cycles. invert changes only on entry to UPDATE, never during it. Next state: SWITCH.
- SWITCH (1 cycle): buffer_switch_done=1. Next state: DISPLAY.
- DISPLAY: holds DISPLAY_CYCLES cycles, then:
  - If bal_q=1 and invert=0: set invert=1 and return to UPDATE (no new data, line_count unchanged).
  - Otherwise: invert=0, frame_count+1 (wrapping), go to FRAME_START.
- invert=1 is never asserted when bal_q=0.
- Per-frame timing:
  - Normal frame: 1 + Σ(wait) + LINES_PER_FRAME×LINE_CYCLES + UPDATE_CYCLES + 1 + DISPLAY_CYCLES cycles.
  - Balanced frame adds a further UPDATE_CYCLES + 1 + DISPLAY_CYCLES.
- Counter width rules:
  - Phase counter width is clog2 of the maximum timing parameter.
  - line_count stays at LINES_PER_FRAME (saturated) from UPDATE until the next FRAME_START. It must therefore be sized clog2(LINES_PER_FRAME+1) internally; the port shows the low bits.
- Parameter constraints: all cycle parameters ≥1, LINES_PER_FRAME ≥1. Elaboration error otherwise.

Decomposition:
- Shared package timing_pkg holds:
  - the state enum (POWERUP, FRAME_START, WAIT_LINE, LINE, UPDATE, SWITCH, DISPLAY);
  - the default timing constants;
  - a clog2 function.
- One sub-module, phase_counter: a loadable down-counter with a done flag, async reset. It is instantiated once and reloaded on each state entry with the state's cycle count.

Test Plan (LINES=4, LINE_CYCLES=8, UPDATE_CYCLES=3, DISPLAY_CYCLES=10, POWERUP_CYCLES=5):
- Reset release, almost_full held 1, bal=0 → reset_per_frame pulses on cycle 6. Four 8-cycle line_of_data_available bursts with 1-cycle gaps. update high 3 cycles, then buffer_switch_done 1 cycle. frame_count=1 after display; invert stays 0.
- Same with bal=1 → two update strobes per frame, invert=0 on the first and 1 on the second, invert stable across each strobe. Only 4 line bursts per frame. frame_count increments once per frame.
- almost_full low for 20 cycles before line 2 → state stays WAIT_LINE, line_count=2, no line_of_data_available until 1 cycle after almost_full rises.
- Toggle dc_balance_en mid-frame (during LINE) → no effect on the current frame; the next frame follows the new value.
- Assert reset_all during the 5th cycle of line 3 → all outputs 0 asynchronously. After release, POWERUP lasts 5 cycles and frame_count restarts at 0.
- FRAME_CNT_W=2, run 5 frames → frame_count sequence 1,2,3,0,1.
